// File: rtl/secuenciador_melodia.sv
// rtl/secuenciador_melodia.sv - melody sequencer: walks the note ROM, plays a square wave per note, then a silent gap
module secuenciador_melodia #(
  parameter int NUM_NOTAS      = 25,
  parameter int TICKS_NOTA     = 12500000,
  parameter int TICKS_SILENCIO = 1250000,
  parameter int ANCHO_DUR      = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        pausa,
  input  logic        detener,
  input  logic        repetir,
  input  logic [15:0] frecuencia_de_nota,
  output logic [4:0]  direccion_nota,
  output logic        salida_audio,
  output logic        reproduciendo,
  output logic        fin
);

  typedef enum logic [2:0] {REPOSO, CARGA, SONANDO, SILENCIO, FIN} estado_t;

  localparam logic [ANCHO_DUR-1:0] ULT_NOTA = ANCHO_DUR'(TICKS_NOTA - 1);
  localparam logic [ANCHO_DUR-1:0] ULT_SIL  = ANCHO_DUR'((TICKS_SILENCIO > 0) ? TICKS_SILENCIO - 1 : 0);
  localparam logic [4:0]           ULT_DIR  = 5'(NUM_NOTAS - 1);

  estado_t              estado, estado_sig;
  logic [4:0]           dir_sig;
  logic [15:0]          semiperiodo, semi_sig;
  logic [15:0]          cnt_tono, cnt_tono_sig;
  logic [ANCHO_DUR-1:0] cnt_dur, cnt_dur_sig;
  logic                 fase, fase_sig;
  logic                 ultima, congelado;
  estado_t              estado_avance;
  logic [4:0]           dir_avance;

  // Where playback goes once a note's gap has finished
  assign ultima        = (direccion_nota == ULT_DIR);
  assign estado_avance = (ultima && !repetir) ? FIN : CARGA;
  assign dir_avance    = !ultima ? direccion_nota + 5'd1 : (repetir ? 5'd0 : direccion_nota);

  assign congelado     = pausa && (estado == SONANDO || estado == SILENCIO);
  assign salida_audio  = fase && !congelado;
  assign reproduciendo = (estado == CARGA) || (estado == SONANDO) || (estado == SILENCIO);
  assign fin           = (estado == FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado         <= REPOSO;
      direccion_nota <= 5'd0;
      semiperiodo    <= 16'd0;
      cnt_tono       <= 16'd0;
      cnt_dur        <= '0;
      fase           <= 1'b0;
    end else begin
      estado         <= estado_sig;
      direccion_nota <= dir_sig;
      semiperiodo    <= semi_sig;
      cnt_tono       <= cnt_tono_sig;
      cnt_dur        <= cnt_dur_sig;
      fase           <= fase_sig;
    end
  end

  always_comb begin
    estado_sig   = estado;
    dir_sig      = direccion_nota;
    semi_sig     = semiperiodo;
    cnt_tono_sig = cnt_tono;
    cnt_dur_sig  = cnt_dur;
    fase_sig     = fase;
    if (detener) begin
      estado_sig   = REPOSO;
      dir_sig      = 5'd0;
      semi_sig     = 16'd0;
      cnt_tono_sig = 16'd0;
      cnt_dur_sig  = '0;
      fase_sig     = 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (iniciar) begin
            estado_sig = CARGA;
            dir_sig    = 5'd0;
          end
        end
        CARGA: begin
          semi_sig     = frecuencia_de_nota;
          cnt_tono_sig = 16'd0;
          cnt_dur_sig  = '0;
          fase_sig     = 1'b0;
          estado_sig   = SONANDO;
        end
        SONANDO: begin
          if (!pausa) begin
            // A zero half-period is a rest: the tone generator stays idle
            if (semiperiodo != 16'd0) begin
              if (cnt_tono == semiperiodo - 16'd1) begin
                fase_sig     = !fase;
                cnt_tono_sig = 16'd0;
              end else begin
                cnt_tono_sig = cnt_tono + 16'd1;
              end
            end
            if (cnt_dur == ULT_NOTA) begin
              cnt_dur_sig  = '0;
              cnt_tono_sig = 16'd0;
              fase_sig     = 1'b0;
              if (TICKS_SILENCIO == 0) begin
                estado_sig = estado_avance;
                dir_sig    = dir_avance;
              end else begin
                estado_sig = SILENCIO;
              end
            end else begin
              cnt_dur_sig = cnt_dur + 1'b1;
            end
          end
        end
        SILENCIO: begin
          if (!pausa) begin
            if (cnt_dur == ULT_SIL) begin
              cnt_dur_sig = '0;
              estado_sig  = estado_avance;
              dir_sig     = dir_avance;
            end else begin
              cnt_dur_sig = cnt_dur + 1'b1;
            end
          end
        end
        FIN: begin
          estado_sig = REPOSO;
          dir_sig    = 5'd0;
        end
        default: begin
          estado_sig = REPOSO;
          dir_sig    = 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_melodia.sv
// tb/tb_secuenciador_melodia.sv - bench for secuenciador_melodia, one instance with a silent gap and one without
module tb_secuenciador_melodia;
  localparam int NN = 4;
  localparam int TN = 20;

  logic clk = 1'b0;
  logic reset = 1'b1, iniciar = 1'b0, pausa = 1'b0, detener = 1'b0, repetir = 1'b0;
  logic rest_mode = 1'b0;
  logic [15:0] frec_a, frec_b;
  logic [4:0]  dir_a, dir_b;
  logic sal_a, sal_b, rep_a, rep_b, fin_a, fin_b;

  always #5 clk = ~clk;

  assign frec_a = (rest_mode && dir_a == 5'd1) ? 16'd0 : 16'(dir_a) + 16'd2;
  assign frec_b = (rest_mode && dir_b == 5'd1) ? 16'd0 : 16'(dir_b) + 16'd2;

  secuenciador_melodia #(.NUM_NOTAS(NN), .TICKS_NOTA(TN), .TICKS_SILENCIO(4), .ANCHO_DUR(8)) dut_a (
    .clk(clk), .reset(reset), .iniciar(iniciar), .pausa(pausa), .detener(detener), .repetir(repetir),
    .frecuencia_de_nota(frec_a), .direccion_nota(dir_a), .salida_audio(sal_a),
    .reproduciendo(rep_a), .fin(fin_a));

  secuenciador_melodia #(.NUM_NOTAS(NN), .TICKS_NOTA(TN), .TICKS_SILENCIO(0), .ANCHO_DUR(8)) dut_b (
    .clk(clk), .reset(reset), .iniciar(iniciar), .pausa(pausa), .detener(detener), .repetir(repetir),
    .frecuencia_de_nota(frec_b), .direccion_nota(dir_b), .salida_audio(sal_b),
    .reproduciendo(rep_b), .fin(fin_b));

  int checks = 0, failures = 0;
  int ciclo = 0, base = 0, rel_n = 0;
  bit chk_en = 1'b0;

  // Model: position of each instance inside its melody, counted in cycles since the note's load
  bit m_act[2] = '{0, 0};
  bit m_fin[2] = '{0, 0};
  int m_dir[2] = '{0, 0};
  int m_off[2] = '{0, 0};

  int fin_cyc_a, fin_cyc_b, nfin_a, nfin_b, rep_cnt_a, tog_a, hi_cnt_a, hw_lo, hw_hi;
  bit prev_sal_a;

  function automatic int tsil(int m);
    return (m == 0) ? 4 : 0;
  endfunction

  function automatic int rom(int a);
    return (rest_mode && a == 1) ? 0 : a + 2;
  endfunction

  function automatic int exp_sal(int m);
    int k, s;
    if (!m_act[m] || pausa || m_off[m] < 1 || m_off[m] > TN) return 0;
    k = m_off[m] - 1;
    s = rom(m_dir[m]);
    if (s == 0) return 0;
    return ((k / s) % 2);
  endfunction

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s rel_cycle=%0d got=%0d expected=%0d", n, ciclo - base, got, exp);
    end
  endtask

  always @(posedge clk) ciclo <= ciclo + 1;

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      automatic bit a = m_act[m];
      automatic bit f = m_fin[m];
      automatic int d = m_dir[m];
      automatic int o = m_off[m];
      if (reset || detener) begin
        a = 0; f = 0; d = 0; o = 0;
      end else if (f) begin
        f = 0; d = 0;
      end else if (!a) begin
        if (iniciar) begin a = 1; d = 0; o = 0; end
      end else if (!(pausa && o != 0)) begin
        o++;
        if (o == 1 + TN + tsil(m)) begin
          o = 0;
          if (d < NN - 1) d++;
          else if (repetir) d = 0;
          else begin a = 0; f = 1; end
        end
      end
      m_act[m] <= a;
      m_fin[m] <= f;
      m_dir[m] <= d;
      m_off[m] <= o;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      rel_n = ciclo - base;
      chk("dir_a", int'(dir_a), m_dir[0]);
      chk("sal_a", int'(sal_a), exp_sal(0));
      chk("rep_a", int'(rep_a), int'(m_act[0]));
      chk("fin_a", int'(fin_a), int'(m_fin[0]));
      chk("dir_b", int'(dir_b), m_dir[1]);
      chk("sal_b", int'(sal_b), exp_sal(1));
      chk("rep_b", int'(rep_b), int'(m_act[1]));
      chk("fin_b", int'(fin_b), int'(m_fin[1]));
      if (fin_a) begin nfin_a++; if (fin_cyc_a < 0) fin_cyc_a = rel_n; end
      if (fin_b) begin nfin_b++; if (fin_cyc_b < 0) fin_cyc_b = rel_n; end
      if (rep_a) rep_cnt_a++;
      if (rel_n >= 3 && rel_n <= 26 && sal_a != prev_sal_a) tog_a++;
      prev_sal_a = sal_a;
      if (rel_n >= hw_lo && rel_n <= hw_hi && sal_a) hi_cnt_a++;
    end
  end

  task automatic start(input int lo, input int hi);
    @(posedge clk); #1;
    base = ciclo;
    fin_cyc_a = -1; fin_cyc_b = -1; nfin_a = 0; nfin_b = 0;
    rep_cnt_a = 0; tog_a = 0; hi_cnt_a = 0; hw_lo = lo; hw_hi = hi;
    iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
  endtask

  task automatic drive_to(input int r);
    while (ciclo - base < r) begin @(posedge clk); #1; end
  endtask

  task automatic sample_at(input int r);
    drive_to(r);
    @(negedge clk);
  endtask

  initial begin
    hw_lo = -1; hw_hi = -1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_dir", int'(dir_a), 0);
    chk("rst_sal", int'(sal_a), 0);
    chk("rst_rep", int'(rep_a), 0);
    chk("rst_fin", int'(fin_a), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Normal run, with a stray iniciar mid-melody
    start(2, 21);
    drive_to(40); iniciar = 1'b1;
    drive_to(41); iniciar = 1'b0;
    drive_to(115);
    chk("norm_fin_cycle_a", fin_cyc_a, 101);
    chk("norm_fin_cycle_b", fin_cyc_b, 85);
    chk("norm_fin_count_a", nfin_a, 1);
    chk("norm_playing_cycles", rep_cnt_a, 100);
    chk("note0_toggles", tog_a, 10);
    chk("note0_high_cycles", hi_cnt_a, 10);

    // Rest at address 1
    rest_mode = 1'b1;
    start(26, 50);
    sample_at(51);
    chk("rest_dir_at51", int'(dir_a), 2);
    drive_to(115);
    chk("rest_high_cycles", hi_cnt_a, 0);
    chk("rest_fin_cycle", fin_cyc_a, 101);
    rest_mode = 1'b0;

    // Seven-cycle pause inside note 2
    start(60, 66);
    drive_to(60); pausa = 1'b1;
    drive_to(67); pausa = 1'b0;
    drive_to(120);
    chk("pause_fin_cycle_a", fin_cyc_a, 108);
    chk("pause_fin_cycle_b", fin_cyc_b, 92);
    chk("pause_high_cycles", hi_cnt_a, 0);

    // Repeat, then stop
    repetir = 1'b1;
    start(-1, -1);
    sample_at(101);
    chk("wrap_dir", int'(dir_a), 0);
    chk("wrap_playing", int'(rep_a), 1);
    drive_to(120); detener = 1'b1;
    drive_to(121); detener = 1'b0;
    chk("stop_dir_a", int'(dir_a), 0);
    chk("stop_rep_a", int'(rep_a), 0);
    chk("stop_fin_a", int'(fin_a), 0);
    chk("stop_rep_b", int'(rep_b), 0);
    chk("stop_dir_b", int'(dir_b), 0);
    chk("repeat_fin_count_a", nfin_a, 0);
    chk("repeat_fin_count_b", nfin_b, 0);
    repetir = 1'b0;

    // Reset mid-note, then stop together with start while idle
    start(-1, -1);
    drive_to(30); reset = 1'b1;
    drive_to(31); reset = 1'b0;
    chk("midrst_dir", int'(dir_a), 0);
    chk("midrst_sal", int'(sal_a), 0);
    chk("midrst_rep", int'(rep_a), 0);
    chk("midrst_fin", int'(fin_a), 0);
    drive_to(35); iniciar = 1'b1; detener = 1'b1;
    drive_to(36); iniciar = 1'b0; detener = 1'b0;
    chk("stop_start_rep_a", int'(rep_a), 0);
    chk("stop_start_rep_b", int'(rep_b), 0);
    drive_to(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secuenciador_melodia.md
Name: secuenciador_melodia

Overview:
Sequencer that plays the stored melody. It steps the note ROM address from 0 to NUM_NOTAS-1 and latches each returned half-period value. It generates a square-wave audio output for a fixed note duration and inserts a silent gap between notes. It sits between the user controls (start/pause/stop/repeat) and the note ROM, and drives the buzzer pin.

Parameters:
NUM_NOTAS, 25, number of ROM entries played (addresses 0..NUM_NOTAS-1)
TICKS_NOTA, 12500000, clk cycles a note sounds (must be >= 1)
TICKS_SILENCIO, 1250000, clk cycles of silence after each note (0 allowed = no gap)
ANCHO_DUR, 24, width of duration counter (must hold max(TICKS_NOTA, TICKS_SILENCIO))

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
iniciar  input  1  start request; sampled only in REPOSO
pausa  input  1  level; freezes playback while high
detener  input  1  abort playback, return to idle
repetir  input  1  level; if high at end of last note's gap, wrap to address 0 instead of finishing
frecuencia_de_nota  input  16  half-period in clk cycles from ROM (combinational read); 0 = rest
direccion_nota  output  5  ROM address, registered
salida_audio  output  1  square wave to buzzer
reproduciendo  output  1  high from CARGA through last SILENCIO
fin  output  1  one-cycle pulse when melody completes normally

Behaviour:
- Reset: state REPOSO; direccion_nota=0, salida_audio=0, reproduciendo=0, fin=0; all counters and latched half-period = 0.
- Priority: reset > detener > pausa > normal operation.
- States: REPOSO, CARGA, SONANDO, SILENCIO, FIN.
- REPOSO: if iniciar=1, go to CARGA next cycle with direccion_nota=0 and reproduciendo=1. Otherwise hold. iniciar is ignored in all other states.
- CARGA (exactly 1 cycle): latch semiperiodo <= frecuencia_de_nota (ROM is already addressed by the registered direccion_nota); clear tone and duration counters; salida_audio=0; go to SONANDO.
- SONANDO: tone counter +1 per cycle. When it equals semiperiodo-1, toggle salida_audio and clear the tone counter. If semiperiodo=0, salida_audio stays 0. Duration counter +1 per cycle. On the cycle it equals TICKS_NOTA-1: next state SILENCIO, salida_audio <= 0, duration counter cleared.
- SILENCIO: lasts TICKS_SILENCIO cycles with salida_audio=0. If TICKS_SILENCIO=0, SONANDO's exit takes the SILENCIO-exit path directly. At exit:
  - direccion_nota < NUM_NOTAS-1: direccion_nota+1, go to CARGA.
  - direccion_nota = NUM_NOTAS-1 and repetir=1: direccion_nota <= 0, go to CARGA.
  - direccion_nota = NUM_NOTAS-1 and repetir=0: go to FIN.
- FIN (1 cycle): fin=1, reproduciendo=0; next cycle REPOSO with direccion_nota=0, fin=0.
- Per-note period: 1 + TICKS_NOTA + TICKS_SILENCIO cycles. The first salida_audio edge occurs semiperiodo cycles after entering SONANDO.
- pausa=1 in SONANDO or SILENCIO: all counters, state and direccion_nota frozen; salida_audio output forced 0; internal tone phase preserved. On release, playback resumes exactly where frozen. pausa has no effect in REPOSO, CARGA or FIN; CARGA always completes.
- detener=1 in any state: next cycle REPOSO, direccion_nota=0, salida_audio=0, reproduciendo=0, no fin pulse. detener with iniciar in REPOSO: stays in REPOSO.
- reset mid-note: same values as power-on reset; no fin pulse.
- direccion_nota never exceeds NUM_NOTAS-1.

Test Plan:
- Bench setup: NUM_NOTAS=4, TICKS_NOTA=20, TICKS_SILENCIO=4; stand-in ROM returns direccion_nota+2.
- Normal run: iniciar pulse at cycle 0 -> CARGA at cycle 1; addresses 0,1,2,3 each held 25 cycles; fin high exactly at cycle 101; reproduciendo high cycles 1..100.
- Tone timing: note 0 (semiperiodo=2) -> salida_audio toggles every 2 cycles, 10 toggles during SONANDO, 0 during the 4 silent cycles.
- Rest handling: stand-in ROM returns 0 for address 1 -> salida_audio stays 0 throughout note 1; address still advances after 25 cycles.
- Pause: pausa high 7 cycles mid-note 2 -> salida_audio=0 during pause; fin delayed by exactly 7 cycles (cycle 108); tone phase continues unchanged after release.
- Repeat / stop: repetir=1 -> after address 3 the address wraps to 0, no fin pulse. Then detener pulse -> next cycle REPOSO, address 0, reproduciendo=0, no fin pulse.
- Boundaries: TICKS_SILENCIO=0 -> per-note period 21 cycles, fin at cycle 85. Reset asserted mid-note -> all outputs 0 next cycle. iniciar asserted while playing -> ignored.
